// File: rtl/stack_driver.sv
// Request/response front end that sequences push/pop pulses to an attached stack.
// Define STACK_DRV_PEEK_EN to build peek support (pop, capture, re-push).
module stack_driver #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [WIDTH-1:0]         req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     push,
    output logic                     pop,
    output logic [WIDTH-1:0]         value_in,
    input  logic [WIDTH-1:0]         value_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPT,
`ifdef STACK_DRV_PEEK_EN
        REPUSH,
`endif
        RESP
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic             err_q;
    logic             accept;
    logic             bad;

    assign accept = req_valid && req_ready;

    // Request legality is judged against the occupancy at the accept edge.
    always_comb begin
        bad = 1'b0;
        case (req_op)
            OP_PUSH: bad = (count == FULL);
            OP_POP:  bad = (count == '0);
`ifdef STACK_DRV_PEEK_EN
            OP_PEEK: bad = (count == '0);
`else
            OP_PEEK: bad = 1'b1;
`endif
            default: bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nxt = bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                nxt = (op_q == OP_PUSH) ? RESP : CAPT;
            end
            CAPT: begin
`ifdef STACK_DRV_PEEK_EN
                nxt = (op_q == OP_PEEK) ? REPUSH : RESP;
`else
                nxt = RESP;
`endif
            end
`ifdef STACK_DRV_PEEK_EN
            REPUSH: begin
                nxt = RESP;
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        value_in  = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            ISSUE: begin
                push     = (op_q == OP_PUSH);
                pop      = (op_q != OP_PUSH);
                value_in = (op_q == OP_PUSH) ? data_q : '0;
            end
`ifdef STACK_DRV_PEEK_EN
            REPUSH: begin
                push     = 1'b1;
                value_in = data_q;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = data_q;
                rsp_err   = err_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // data_q holds the echo for push, then the stack word once captured.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            count  <= '0;
        end else begin
            if (accept) begin
                op_q   <= req_op;
                err_q  <= bad;
                data_q <= bad ? '0 : req_data;
            end
            if (state == CAPT) begin
                data_q <= value_out;
            end
            if (push && count != FULL) begin
                count <= count + 1'b1;
            end else if (pop && count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_driver.sv
// Scoreboard bench for stack_driver with a behavioural stack model.
// Honours STACK_DRV_PEEK_EN to choose the expected peek behaviour.
module tb_stack_driver;

    localparam int DEPTH = 8;
    localparam int W     = 16;
`ifdef STACK_DRV_PEEK_EN
    localparam bit PEEK = 1'b1;
`else
    localparam bit PEEK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [W-1:0] req_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic         push;
    logic         pop;
    logic [W-1:0] value_in;
    logic [W-1:0] value_out;
    logic [$clog2(DEPTH):0] count;

    stack_driver #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .push(push), .pop(pop),
        .value_in(value_in), .value_out(value_out),
        .count(count)
    );

    always #5 clk = ~clk;

    // Attached stack: read data appears the cycle after pop.
    logic [W-1:0] smem [DEPTH];
    int sp = 0;
    always @(posedge clk) begin
        if (!reset) begin
            sp <= 0;
            value_out <= '0;
        end else if (push && sp < DEPTH) begin
            smem[sp] <= value_in;
            sp <= sp + 1;
        end else if (pop && sp > 0) begin
            value_out <= smem[sp-1];
            sp <= sp - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] data;
        bit           err;
        int           lat;
        int           cnt;
        int           npush;
        int           npop;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mdl[$];
    exp_t         mon_e;
    int n_pass = 0;
    int n_tot = 0;
    int push_n = 0;
    int pop_n = 0;
    int base_push = 0;
    int base_pop = 0;
    bit in_rsp = 0;
    bit stall_req = 0;
    int stall = 0;
    logic [W-1:0] hold_data;
    logic         hold_err;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_tot++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Reference: a plain queue, top of stack at the back.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] d);
        exp_t e;
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_data = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tot++;
            $display("FAIL accept_timeout: op %0d not accepted", op);
            req_valid = 1'b0;
            return;
        end
        e.acc = cyc; e.data = '0; e.err = 1'b0;
        e.npush = 0; e.npop = 0; e.lat = 1;
        case (op)
            2'b01: if (mdl.size() < DEPTH) begin
                mdl.push_back(d);
                e.data = d; e.lat = 2; e.npush = 1;
            end else e.err = 1'b1;
            2'b10: if (mdl.size() > 0) begin
                e.data = mdl.pop_back();
                e.lat = 3; e.npop = 1;
            end else e.err = 1'b1;
            2'b11: if (PEEK && mdl.size() > 0) begin
                e.data = mdl[$];
                e.lat = 4; e.npush = 1; e.npop = 1;
            end else e.err = 1'b1;
            default: e.err = 1'b1;
        endcase
        e.cnt = mdl.size();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_data = '0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (push) push_n++;
            if (pop) pop_n++;
            chk("push_pop_excl", 64'(push & pop), 64'd0);
            chk("value_in_idle", (!push) ? 64'(value_in) : 64'd0, 64'd0);
            if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1;
                    if (exp_q.size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_rsp: got data %0h", rsp_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                        chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                        chk("count", 64'(count), 64'(mon_e.cnt));
                        chk("push_pulses", 64'(push_n - base_push), 64'(mon_e.npush));
                        chk("pop_pulses", 64'(pop_n - base_pop), 64'(mon_e.npop));
                    end
                    hold_data = rsp_data;
                    hold_err = rsp_err;
                    if (stall_req) begin
                        stall = 5;
                        stall_req = 0;
                    end
                end else begin
                    chk("hold_data", 64'(rsp_data), 64'(hold_data));
                    chk("hold_err", 64'(rsp_err), 64'(hold_err));
                    chk("req_ready_low", 64'(req_ready), 64'd0);
                end
            end
            if (stall > 0) begin
                rsp_ready = 1'b0;
                stall--;
            end else begin
                rsp_ready = ($urandom_range(0, 2) != 0);
            end
            if (in_rsp && rsp_valid && rsp_ready) begin
                in_rsp = 0;
                base_push = push_n;
                base_pop = pop_n;
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_push", 64'(push), 64'd0);
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_value_in", 64'(value_in), 64'd0);
        chk("rst_count", 64'(count), 64'd0);

        issue(2'b01, 16'h0013);
        issue(2'b01, 16'h00a5);
        issue(2'b10, 16'h0000);
        issue(2'b10, 16'h0000);
        issue(2'b10, 16'h0000);
        for (int i = 0; i <= DEPTH; i++) issue(2'b01, 16'($urandom));
        for (int i = 0; i < DEPTH; i++) issue(2'b10, 16'h0000);
        issue(2'b01, 16'h0014);
        issue(2'b11, 16'h0000);
        issue(2'b10, 16'h0000);
        issue(2'b11, 16'h0000);
        issue(2'b00, 16'h1234);
        stall_req = 1;
        issue(2'b01, 16'h0bee);

        for (int i = 0; i < 150; i++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 9) < 5) ? 2'b01 : 2'($urandom_range(0, 3));
            issue(op, 16'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Abort a pop while the stack word is being captured.
        issue(2'b01, 16'h0f0f);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        issue(2'b10, 16'h0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pop && n < 10);
        chk("abort_pop_seen", 64'(pop), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        mdl.delete();
        in_rsp = 0;
        base_push = push_n;
        base_pop = pop_n;
        @(negedge clk);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_count", 64'(count), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_push", 64'(push_n - base_push), 64'd0);
        chk("abort_no_pop", 64'(pop_n - base_pop), 64'd0);
        issue(2'b10, 16'h0000);
        issue(2'b01, 16'h0077);
        issue(2'b10, 16'h0000);

        n = 0;
        while ((exp_q.size() != 0 || in_rsp) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/stack_driver.md
STACK_DRIVER -- requirements
Module: stack_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 8: capacity of the attached stack, in entries.
REQ-002 SHALL have parameter WIDTH, default 16: data width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: request offered.
REQ-006 SHALL have port req_ready, output, 1: request accepted when high together with req_valid.
REQ-007 SHALL have port req_op, input, 2: 01 push, 10 pop, 11 peek, 00 illegal.
REQ-008 SHALL have port req_data, input, WIDTH: push data.
REQ-009 SHALL have port rsp_valid, output, 1: response present.
REQ-010 SHALL have port rsp_ready, input, 1: response consumed when high together with rsp_valid.
REQ-011 SHALL have port rsp_data, output, WIDTH: popped/peeked data; echo of req_data for push; 0 on error.
REQ-012 SHALL have port rsp_err, output, 1: request rejected.
REQ-013 SHALL have ports push, pop, value_in (outputs, 1/1/WIDTH) and value_out (input, WIDTH): drive the stack's command interface.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1: current stack occupancy.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, CAPT, REPUSH, RESP.
REQ-016 SHALL assert req_ready only in IDLE and hold all other handshake outputs low in IDLE.
REQ-017 On accept, SHALL register req_op and req_data; from IDLE:
- legal push or pop -> ISSUE;
- error -> RESP.
REQ-018 Error cases SHALL be: push with count==DEPTH; pop or peek with count==0; op 00.
REQ-019 On error, SHALL pulse neither push nor pop, and SHALL respond with rsp_err=1 and rsp_data=0.
REQ-020 ISSUE push SHALL:
- assert push for exactly one cycle with value_in=req_data;
- increment count;
- go to RESP.
REQ-021 ISSUE pop/peek SHALL:
- assert pop for exactly one cycle;
- decrement count;
- go to CAPT.
REQ-022 CAPT SHALL sample value_out (the stack's data is valid the cycle after pop) into rsp_data, then go to RESP (pop) or REPUSH (peek).
REQ-023 REPUSH SHALL assert push for exactly one cycle with value_in=captured data, restore count, and go to RESP.
REQ-024 push and pop SHALL never both be high in one cycle.
REQ-025 value_in SHALL be 0 whenever push is low.
REQ-026 RESP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready, then return to IDLE.
REQ-027 Latency from accept cycle N to first rsp_valid cycle SHALL be:
- error N+1;
- push N+2;
- pop N+3;
- peek N+4.
REQ-028 count SHALL saturate within 0..DEPTH and change only on issued push/pop pulses.

Reset
REQ-029 When reset is low at a clock edge, SHALL enter IDLE and clear all outputs and count to 0, abandoning any in-flight request without further push/pop pulses.
REQ-030 The attached stack SHALL share the same reset, so count=0 matches an empty stack.

Configuration
REQ-031 Macro STACK_DRV_PEEK_EN SHALL control peek support.
- Defined: op 11 performs peek per REQ-021..REQ-023.
- Undefined: op 11 is an error per REQ-019; REPUSH state is not built.

Verification
REQ-032 Push 16'h0013 then push 16'h00a5 -> two push pulses, responses echo the data with rsp_err=0, count=2.
REQ-033 From that state, pop twice -> rsp_data 16'h00a5 then 16'h0013, count=0, pop latency exactly 3 cycles.
REQ-034 Pop on empty -> rsp_err=1, rsp_data=0, no pop pulse, rsp_valid at N+1; push DEPTH+1 times -> last response rsp_err=1, count=DEPTH.
REQ-035 With STACK_DRV_PEEK_EN, push 16'h0014, then peek -> rsp_data 16'h0014, count=1, pop then push pulses observed; without the macro -> rsp_err=1.
REQ-036 Hold rsp_ready low 5 cycles -> response stable, req_ready low; assert reset mid-pop (during CAPT) -> next cycle IDLE, count=0, no further pulses.
